axis_mvm_rx_decoder: RTL and testbench
======================================

AXIS_MVM_RX_DECODER -- requirements
Module: axis_mvm_rx_decoder

Interface
REQ-001 Parameter DATAW, default 512: payload width of tdata, without the appended user field.
REQ-002 Parameter USERW, default 75: user field width, appended above the payload in tdata.
REQ-003 Parameter IDW, default 2; DESTW, default 4: widths of tid and tdest.
REQ-004 Parameter DPES, default 64: number of dot-product engines, which sets the width of rf_wen.
REQ-005 Parameter IN_FIFO_DEPTH, default 4: depth of the input-vector FIFO, a power of two.
REQ-006 clk  in  1  single clock; all logic on its rising edge.
REQ-007 rst_n  in  1  reset, synchronous, active-low.
REQ-008 axis_rx_tvalid/axis_rx_tready  in/out  1/1  AXI-S handshake from NoC egress.
REQ-009 axis_rx_tdata  in  DATAW+USERW  payload [DATAW-1:0]; user field [DATAW+USERW-1:DATAW].
REQ-010 axis_rx_tlast  in  1; axis_rx_tid  in  IDW; axis_rx_tdest  in  DESTW: tid/tdest are accepted and ignored.
REQ-011 inst_wen/inst_waddr/inst_wdata  out  1/9/32  instruction memory write port.
REQ-012 rf_wen/rf_waddr/rf_wdata  out  DPES/9/DATAW  weight register-file write port; rf_wen is one-hot.
REQ-013 in_valid/in_ready/in_data/in_last  out/in/out/out  1/1/DATAW/1  input-vector stream to the datapath.
REQ-014 inst_load_done  out  1  one-cycle pulse when an instruction load completes.
REQ-015 err_count  out  16  saturating count of malformed beats.

Function
REQ-016 User field decode: addr = user[8:0]; op = user[10:9]; rf_en = user[74:11], of which bits [DPES-1:0] are used.
REQ-017 Op encodings: 0 = instruction, 1 = input vector, 2 = reserved, 3 = weight.
REQ-018 A beat is accepted on the rising edge where tvalid and tready are both high.
REQ-019 axis_rx_tready = !fifo_full; it is registered-state driven and never depends on tdata.
REQ-020 Op 0: one cycle after acceptance, inst_wen=1, inst_wdata=payload[31:0], inst_waddr=inst_ptr; inst_ptr then increments.
REQ-021 inst_ptr is 9 bits and wraps 511->0.
REQ-022 Op 0 with tlast=1: inst_load_done pulses high in the same cycle as that beat's inst_wen, and inst_ptr returns to 0.
REQ-023 Op 3 with rf_en exactly one-hot in [DPES-1:0]: one cycle after acceptance, rf_wen=rf_en, rf_waddr=addr, rf_wdata=payload.
REQ-024 Op 3 with rf_en zero or multi-hot: the beat is dropped, rf_wen stays 0, and err_count increments.
REQ-025 Op 2: the beat is dropped and err_count increments.
REQ-026 err_count saturates at 16'hFFFF.
REQ-027 Op 1: payload and tlast are pushed into the input FIFO on the accept edge.
REQ-028 The input FIFO is show-ahead: in_valid = !empty, and in_data/in_last come from the head entry.
REQ-029 The input FIFO pops when in_valid and in_ready are both high.
REQ-030 Push and pop in the same cycle leave the count unchanged.
REQ-031 Accept-to-in_valid latency into an empty FIFO is 1 cycle.
REQ-032 Full FIFO: tready=0 for all ops (head-of-line blocking is intended); tready returns to 1 the cycle after a pop.
REQ-033 inst_wen and rf_wen are never asserted in the same cycle, since at most one beat is accepted per cycle.

Reset
REQ-034 With rst_n=0 at a rising edge: all write enables, inst_load_done, in_valid and tready become 0; inst_ptr, err_count and the FIFO pointers are cleared.
REQ-035 Reset mid-packet discards FIFO contents and any pending registered write.
REQ-036 The first beat after reset lands at inst_ptr=0.
REQ-037 tready rises on the first cycle after rst_n deasserts.

Structure
REQ-038 Package mvm_pkg holds the op enum (OP_INST, OP_INPUT, OP_RSVD, OP_WEIGHT) and the field offsets ADDR_LSB=0, OP_LSB=9, RFEN_LSB=11.
REQ-039 The input FIFO is a sub-module, mvm_rx_fifo (parameters WIDTH, DEPTH), with outputs full and empty.
REQ-040 The decode and registered write stage stays in the top module.

Verification
REQ-041 Send 3 op-0 beats 0x11, 0x22, 0x33 with tlast on the third -> inst_waddr 0,1,2 and inst_wdata in order; inst_load_done pulses once, coincident with addr 2; the next load starts at 0.
REQ-042 Send op 3, rf_en=1<<5, addr=7, payload=P -> rf_wen=0x20, rf_waddr=7, rf_wdata=P, exactly one cycle after accept.
REQ-043 Send op 3 with rf_en=0x3, then op 2 -> no writes; err_count=2.
REQ-044 Hold in_ready=0 and send 5 op-1 beats -> 4 accepted, tready=0 on the 5th; raise in_ready -> 5 vectors out in order, last flag on the 5th only.
REQ-045 Assert rst_n=0 with 2 vectors queued and inst_ptr=5 -> in_valid=0; after release, the next op-0 beat writes address 0.
REQ-046 Force err_count to 16'hFFFE, then send 3 bad beats -> err_count holds at 16'hFFFF.

Source files
------------

// File: rtl/mvm_pkg.sv
// Shared definitions for the MVM NoC receive path: user-field layout, op codes
// and the saturating error-count helper.
package mvm_pkg;

  typedef enum logic [1:0] {
    OP_INST   = 2'd0,
    OP_INPUT  = 2'd1,
    OP_RSVD   = 2'd2,
    OP_WEIGHT = 2'd3
  } op_e;

  localparam int ADDR_LSB = 0;
  localparam int ADDR_W   = 9;
  localparam int OP_LSB   = 9;
  localparam int OP_W     = 2;
  localparam int RFEN_LSB = 11;
  localparam int INST_W   = 32;
  localparam int ERR_W    = 16;

  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (v == ERR_MAX) ? v : v + ERR_W'(1);
  endfunction

endpackage

// File: rtl/mvm_rx_fifo.sv
// Show-ahead FIFO for input vectors; head entry is visible whenever not empty.
module mvm_rx_fifo #(
  parameter int WIDTH = 513,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full      = (count == (AW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign do_push   = push & ~full;
  assign do_pop    = pop & ~empty;
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked entirely by count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/axis_mvm_rx_decoder.sv
// Decodes AXI-Stream beats from the NoC into instruction writes, one-hot weight
// register-file writes and a buffered input-vector stream.
module axis_mvm_rx_decoder
  import mvm_pkg::*;
#(
  parameter int DATAW         = 512,
  parameter int USERW         = 75,
  parameter int IDW           = 2,
  parameter int DESTW         = 4,
  parameter int DPES          = 64,
  parameter int IN_FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   axis_rx_tvalid,
  output logic                   axis_rx_tready,
  input  logic [DATAW+USERW-1:0] axis_rx_tdata,
  input  logic                   axis_rx_tlast,
  input  logic [IDW-1:0]         axis_rx_tid,
  input  logic [DESTW-1:0]       axis_rx_tdest,
  output logic                   inst_wen,
  output logic [ADDR_W-1:0]      inst_waddr,
  output logic [INST_W-1:0]      inst_wdata,
  output logic [DPES-1:0]        rf_wen,
  output logic [ADDR_W-1:0]      rf_waddr,
  output logic [DATAW-1:0]       rf_wdata,
  output logic                   in_valid,
  input  logic                   in_ready,
  output logic [DATAW-1:0]       in_data,
  output logic                   in_last,
  output logic                   inst_load_done,
  output logic [ERR_W-1:0]       err_count
);

  logic [DATAW-1:0]  payload;
  logic [USERW-1:0]  user;
  logic [ADDR_W-1:0] addr;
  op_e               op;
  logic [DPES-1:0]   rf_en;
  logic              rf_onehot;

  logic              ready_q;
  logic              accept;
  logic              fifo_full;
  logic              fifo_empty;
  logic [ADDR_W-1:0] inst_ptr;

  logic              do_inst;
  logic              do_input;
  logic              do_weight;
  logic              do_drop;

  // Stream id/dest and any rf_en bits above DPES carry no meaning here.
  logic              unused_fields;
  assign unused_fields = ^{axis_rx_tid, axis_rx_tdest, user};

  assign payload   = axis_rx_tdata[DATAW-1:0];
  assign user      = axis_rx_tdata[DATAW+USERW-1:DATAW];
  assign addr      = user[ADDR_LSB +: ADDR_W];
  assign op        = op_e'(user[OP_LSB +: OP_W]);
  assign rf_en     = user[RFEN_LSB +: DPES];
  assign rf_onehot = $onehot(rf_en);

  // ready_q keeps tready low through reset and for the first cycle after it.
  always_ff @(posedge clk) begin
    if (!rst_n) ready_q <= 1'b0;
    else        ready_q <= 1'b1;
  end

  assign axis_rx_tready = ready_q & ~fifo_full;
  assign accept         = axis_rx_tvalid & axis_rx_tready;

  always_comb begin
    do_inst   = 1'b0;
    do_input  = 1'b0;
    do_weight = 1'b0;
    do_drop   = 1'b0;
    if (accept) begin
      case (op)
        OP_INST:   do_inst  = 1'b1;
        OP_INPUT:  do_input = 1'b1;
        OP_WEIGHT: begin
          if (rf_onehot) do_weight = 1'b1;
          else           do_drop   = 1'b1;
        end
        default:   do_drop  = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inst_wen       <= 1'b0;
      inst_load_done <= 1'b0;
      rf_wen         <= '0;
      inst_ptr       <= '0;
      err_count      <= '0;
    end else begin
      inst_wen       <= do_inst;
      inst_load_done <= do_inst & axis_rx_tlast;
      rf_wen         <= do_weight ? rf_en : '0;
      if (do_inst) inst_ptr <= axis_rx_tlast ? '0 : inst_ptr + ADDR_W'(1);
      if (do_drop) err_count <= sat_inc(err_count);
    end
  end

  // Write address/data are qualified by the enables, so they need no reset.
  always_ff @(posedge clk) begin
    if (do_inst) begin
      inst_waddr <= inst_ptr;
      inst_wdata <= payload[INST_W-1:0];
    end
    if (do_weight) begin
      rf_waddr <= addr;
      rf_wdata <= payload;
    end
  end

  mvm_rx_fifo #(
    .WIDTH (DATAW + 1),
    .DEPTH (IN_FIFO_DEPTH)
  ) u_in_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (do_input),
    .push_data ({axis_rx_tlast, payload}),
    .pop       (in_valid & in_ready),
    .head_data ({in_last, in_data}),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign in_valid = ~fifo_empty;

endmodule

// File: tb/tb_axis_mvm_rx_decoder.sv
// Scoreboard bench for axis_mvm_rx_decoder: a driver predicts each accepted
// beat's effect into queues, a negedge monitor pops and compares.
module tb_axis_mvm_rx_decoder;

  localparam int DATAW = 512;
  localparam int USERW = 75;
  localparam int IDW   = 2;
  localparam int DESTW = 4;
  localparam int DPES  = 64;
  localparam int DEPTH = 4;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   axis_rx_tvalid = 1'b0;
  logic                   axis_rx_tready;
  logic [DATAW+USERW-1:0] axis_rx_tdata = '0;
  logic                   axis_rx_tlast = 1'b0;
  logic [IDW-1:0]         axis_rx_tid = '0;
  logic [DESTW-1:0]       axis_rx_tdest = '0;
  logic                   inst_wen;
  logic [8:0]             inst_waddr;
  logic [31:0]            inst_wdata;
  logic [DPES-1:0]        rf_wen;
  logic [8:0]             rf_waddr;
  logic [DATAW-1:0]       rf_wdata;
  logic                   in_valid;
  logic                   in_ready = 1'b0;
  logic [DATAW-1:0]       in_data;
  logic                   in_last;
  logic                   inst_load_done;
  logic [15:0]            err_count;

  axis_mvm_rx_decoder #(
    .DATAW(DATAW), .USERW(USERW), .IDW(IDW), .DESTW(DESTW),
    .DPES(DPES), .IN_FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .axis_rx_tvalid(axis_rx_tvalid), .axis_rx_tready(axis_rx_tready),
    .axis_rx_tdata(axis_rx_tdata), .axis_rx_tlast(axis_rx_tlast),
    .axis_rx_tid(axis_rx_tid), .axis_rx_tdest(axis_rx_tdest),
    .inst_wen(inst_wen), .inst_waddr(inst_waddr), .inst_wdata(inst_wdata),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .inst_load_done(inst_load_done), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct { logic [8:0] addr; logic [31:0] data; logic done; int cyc; } inst_t;
  typedef struct { logic [DPES-1:0] wen; logic [8:0] addr; logic [DATAW-1:0] data; int cyc; } rf_t;
  typedef struct { logic [DATAW-1:0] data; logic last; } vec_t;

  inst_t inst_q[$];
  rf_t   rf_q[$];
  vec_t  vec_q[$];

  int          exp_ptr = 0;
  logic [15:0] exp_err = '0;
  bit          chk_err_en = 1'b0;
  int          rdy_mode = 0;   // 0 = hold low, 1 = hold high, 2 = random

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chkd(input string name, input logic [DATAW-1:0] act, input logic [DATAW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int ones(input logic [63:0] v);
    int n = 0;
    for (int i = 0; i < DPES; i++) if (v[i]) n++;
    return n;
  endfunction

  function automatic logic [DATAW-1:0] rnd_payload();
    logic [DATAW-1:0] p;
    for (int i = 0; i < DATAW/32; i++) p[i*32 +: 32] = $urandom;
    return p;
  endfunction

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       in_ready = 1'b0;
      1:       in_ready = 1'b1;
      default: in_ready = 1'($urandom_range(0, 1));
    endcase
  end

  inst_t ie;
  rf_t   re;
  vec_t  ve;

  always @(negedge clk) begin
    if (inst_wen && rf_wen != '0) begin
      checks++; errors++;
      $display("FAIL write_overlap: inst_wen and rf_wen %0h together", rf_wen);
    end
    if (inst_load_done && !inst_wen) begin
      checks++; errors++;
      $display("FAIL load_done_alone: inst_load_done without inst_wen");
    end
    if (inst_wen) begin
      if (inst_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL inst_unexpected: write addr %0h data %0h, none required", inst_waddr, inst_wdata);
      end else begin
        ie = inst_q.pop_front();
        chk64("inst_waddr", 64'(inst_waddr), 64'(ie.addr));
        chk64("inst_wdata", 64'(inst_wdata), 64'(ie.data));
        chk64("inst_load_done", 64'(inst_load_done), 64'(ie.done));
        chk64("inst_latency", 64'(cyc), 64'(ie.cyc));
      end
    end
    if (rf_wen != '0) begin
      if (rf_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rf_unexpected: rf_wen %0h addr %0h, none required", rf_wen, rf_waddr);
      end else begin
        re = rf_q.pop_front();
        chk64("rf_wen", 64'(rf_wen), 64'(re.wen));
        chk64("rf_waddr", 64'(rf_waddr), 64'(re.addr));
        chkd("rf_wdata", rf_wdata, re.data);
        chk64("rf_latency", 64'(cyc), 64'(re.cyc));
      end
    end
    if (in_valid && in_ready) begin
      if (vec_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL vec_unexpected: vector popped, none required");
      end else begin
        ve = vec_q.pop_front();
        chkd("in_data", in_data, ve.data);
        chk64("in_last", 64'(in_last), 64'(ve.last));
      end
    end
    if (chk_err_en) chk64("err_count", 64'(err_count), 64'(exp_err));
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send_beat(input logic [1:0] op, input logic [8:0] addr, input logic [63:0] rfen,
                           input logic [DATAW-1:0] pl, input logic last);
    int waitc;
    bit done;
    bit bad;
    waitc = 0; done = 1'b0; bad = 1'b0;
    axis_rx_tdata = '0;
    axis_rx_tdata[DATAW-1:0] = pl;
    axis_rx_tdata[DATAW +: 9] = addr;
    axis_rx_tdata[DATAW+9 +: 2] = op;
    axis_rx_tdata[DATAW+11 +: 64] = rfen;
    axis_rx_tlast = last;
    axis_rx_tid = IDW'($urandom);
    axis_rx_tdest = DESTW'($urandom);
    axis_rx_tvalid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (axis_rx_tready) begin
        done = 1'b1;
        case (op)
          2'd0: begin
            inst_q.push_back('{addr: 9'(exp_ptr), data: pl[31:0], done: last, cyc: cyc + 1});
            exp_ptr = last ? 0 : (exp_ptr + 1) % 512;
          end
          2'd1: vec_q.push_back('{data: pl, last: last});
          2'd2: bad = 1'b1;
          default: begin
            if (ones(rfen) == 1) rf_q.push_back('{wen: rfen[DPES-1:0], addr: addr, data: pl, cyc: cyc + 1});
            else bad = 1'b1;
          end
        endcase
      end else begin
        waitc++;
        if (waitc > 500) begin
          checks++; errors++;
          $display("FAIL tready_timeout: tready 0 for %0d cycles, required 1", waitc);
          axis_rx_tvalid = 1'b0;
          done = 1'b1;
        end
      end
      @(posedge clk); #1;
    end
    axis_rx_tvalid = 1'b0;
    if (bad && exp_err != 16'hFFFF) exp_err = exp_err + 16'd1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk64({tag, "_tready"}, 64'(axis_rx_tready), 64'd0);
    chk64({tag, "_in_valid"}, 64'(in_valid), 64'd0);
    chk64({tag, "_inst_wen"}, 64'(inst_wen), 64'd0);
    chk64({tag, "_rf_wen"}, 64'(rf_wen), 64'd0);
    chk64({tag, "_load_done"}, 64'(inst_load_done), 64'd0);
    chk64({tag, "_err_count"}, 64'(err_count), 64'd0);
  endtask

  initial begin
    #1_500_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    logic [DATAW-1:0] p;
    logic [63:0]      rfen;
    int               b0, b1;

    // power-on reset and tready release timing
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("por");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk64("tready_pre_edge", 64'(axis_rx_tready), 64'd0);
    @(negedge clk);
    chk64("tready_after_reset", 64'(axis_rx_tready), 64'd1);
    @(posedge clk); #1;
    chk_err_en = 1'b1;

    // instruction load with tlast, then next load restarts at 0
    send_beat(2'd0, 9'h0, 64'h0, DATAW'(32'h11), 1'b0);
    send_beat(2'd0, 9'h0, 64'h0, DATAW'(32'h22), 1'b0);
    send_beat(2'd0, 9'h0, 64'h0, DATAW'(32'h33), 1'b1);
    send_beat(2'd0, 9'h0, 64'h0, DATAW'(32'h44), 1'b1);
    idle(3);

    // one-hot weight write
    p = rnd_payload();
    send_beat(2'd3, 9'd7, 64'h20, p, 1'b0);
    idle(3);

    // malformed beats
    send_beat(2'd3, 9'd3, 64'h3, rnd_payload(), 1'b0);
    send_beat(2'd2, 9'd4, 64'h0, rnd_payload(), 1'b0);
    idle(2);
    chk64("err_after_two_bad", 64'(err_count), 64'd2);

    // fill FIFO with in_ready low, then drain
    rdy_mode = 0;
    idle(1);
    send_beat(2'd1, 9'd0, 64'h0, rnd_payload(), 1'b0);
    @(negedge clk);
    chk64("in_valid_latency", 64'(in_valid), 64'd1);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) send_beat(2'd1, 9'd0, 64'h0, rnd_payload(), 1'b0);
    @(negedge clk);
    chk64("tready_full", 64'(axis_rx_tready), 64'd0);
    @(posedge clk); #1;
    rdy_mode = 1;
    send_beat(2'd1, 9'd0, 64'h0, rnd_payload(), 1'b1);
    idle(10);
    chk64("vec_drained", 64'(vec_q.size()), 64'd0);

    // reset with vectors queued, inst_ptr at 5 and a beat on the reset edge
    rdy_mode = 0;
    send_beat(2'd0, 9'd0, 64'h0, rnd_payload(), 1'b1);
    for (int i = 0; i < 5; i++) send_beat(2'd0, 9'd0, 64'h0, rnd_payload(), 1'b0);
    send_beat(2'd1, 9'd0, 64'h0, rnd_payload(), 1'b0);
    send_beat(2'd1, 9'd0, 64'h0, rnd_payload(), 1'b1);
    idle(3);
    @(negedge clk);
    chk64("in_valid_before_reset", 64'(in_valid), 64'd1);
    @(posedge clk); #1;
    chk_err_en = 1'b0;
    rst_n = 1'b0;
    axis_rx_tdata = '0;
    axis_rx_tvalid = 1'b1;
    @(posedge clk); #1;
    axis_rx_tvalid = 1'b0;
    vec_q.delete();
    exp_ptr = 0;
    exp_err = '0;
    @(negedge clk);
    chk_reset_outputs("mid_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);
    chk_err_en = 1'b1;
    send_beat(2'd0, 9'd0, 64'h0, rnd_payload(), 1'b0);

    // pointer wrap 511 -> 0
    for (int i = 0; i < 515; i++) send_beat(2'd0, 9'd0, 64'h0, DATAW'(i), 1'b0);
    idle(3);

    // randomized traffic
    rdy_mode = 2;
    for (int n = 0; n < 400; n++) begin
      b0 = $urandom_range(0, 9);
      if (b0 == 0) rfen = 64'h0;
      else if (b0 == 1) begin
        b0 = $urandom_range(0, 63);
        b1 = (b0 + $urandom_range(1, 63)) % 64;
        rfen = (64'h1 << b0) | (64'h1 << b1);
      end else rfen = 64'h1 << $urandom_range(0, 63);
      send_beat(2'($urandom_range(0, 3)), 9'($urandom), rfen, rnd_payload(),
                1'($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
    end
    rdy_mode = 1;
    idle(12);

    // saturation of err_count
    while (exp_err < 16'hFFFE) send_beat(2'd2, 9'd0, 64'h0, '0, 1'b0);
    idle(1);
    chk64("err_at_fffe", 64'(err_count), 64'hFFFE);
    send_beat(2'd2, 9'd1, 64'h0, '0, 1'b0);
    send_beat(2'd3, 9'd2, 64'h0, '0, 1'b0);
    send_beat(2'd3, 9'd3, 64'hF0, '0, 1'b0);
    idle(2);
    chk64("err_saturated", 64'(err_count), 64'hFFFF);

    idle(5);
    chk64("inst_q_empty", 64'(inst_q.size()), 64'd0);
    chk64("rf_q_empty", 64'(rf_q.size()), 64'd0);
    chk64("vec_q_empty", 64'(vec_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
